// File: rtl/kd_pkg.sv
// Shared definitions for the kd-tree sequencer: point/center widths and the
// controller state encoding.
package kd_pkg;

    localparam int DIM         = 3;
    localparam int DATA_RANGE  = 255;
    localparam int DIM_SIZE    = $clog2(DATA_RANGE);
    localparam int CENTER_SIZE = DIM * DIM_SIZE;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SORT  = 3'd1,
        ST_FETCH = 3'd2,
        ST_PROP  = 3'd3,
        ST_EMIT  = 3'd4,
        ST_DONE  = 3'd5
    } kd_state_e;

    // Compared one bit wider so a 65535-point run cannot wrap.
    function automatic logic is_last_point(input logic [15:0] cnt, input logic [15:0] num);
        return (({1'b0, cnt} + 17'd1) == {1'b0, num});
    endfunction

endpackage

// File: rtl/kd_tree_ctrl_if.sv
// Bundle of run-control, tree-mode, point, best-center and result signals
// between the kd-tree sequencer and its surroundings.
interface kd_tree_ctrl_if #(
    parameter int NUM_CE = 7
);
    logic                            start;
    logic [15:0]                     num_points;
    logic [NUM_CE-1:0]               sort_stable;
    logic                            en;
    logic                            sorting;
    logic                            point_prop;
    logic                            pt_valid;
    logic [kd_pkg::CENTER_SIZE-1:0]  pt_data;
    logic                            pt_ready;
    logic [kd_pkg::CENTER_SIZE-1:0]  root_point;
    logic                            best_valid;
    logic [kd_pkg::CENTER_SIZE-1:0]  best_center;
    logic                            res_valid;
    logic [kd_pkg::CENTER_SIZE-1:0]  res_point;
    logic [kd_pkg::CENTER_SIZE-1:0]  res_center;
    logic                            res_ready;
    logic                            busy;
    logic                            done;
    logic                            err_timeout;

    modport master (
        input  start, num_points, sort_stable, pt_valid, pt_data,
               best_valid, best_center, res_ready,
        output en, sorting, point_prop, pt_ready, root_point,
               res_valid, res_point, res_center, busy, done, err_timeout
    );

    modport slave (
        output start, num_points, sort_stable, pt_valid, pt_data,
               best_valid, best_center, res_ready,
        input  en, sorting, point_prop, pt_ready, root_point,
               res_valid, res_point, res_center, busy, done, err_timeout
    );
endinterface

// File: rtl/kd_stable_detect.sv
// Counts consecutive cycles with every compare-exchange node stable and flags
// the cycle in which the run reaches STABLE_RUN.
module kd_stable_detect #(
    parameter int NUM_CE     = 7,
    parameter int STABLE_RUN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [NUM_CE-1:0] sort_stable,
    output logic              run_done
);
    localparam int            CW      = $clog2(STABLE_RUN + 1);
    localparam logic [CW-1:0] RUN_LEN = CW'(STABLE_RUN);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Saturating run-length counter; any unstable node restarts the run.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (!(&sort_stable)) begin
                cnt_d = '0;
            end else if (cnt_q != RUN_LEN) begin
                cnt_d = cnt_q + CW'(1'b1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign run_done = en && !clr && (cnt_d == RUN_LEN);

    // Run-length register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/kd_tree_ctrl.sv
// kd-tree sequencer: sort phase until stable, then one query point at a time
// through the tree, forwarding each (point, best center) pair downstream.
module kd_tree_ctrl
    import kd_pkg::*;
#(
    parameter int NUM_CE       = 7,
    parameter int STABLE_RUN   = 2,
    parameter int SORT_TIMEOUT = 1024,
    parameter int PROP_TIMEOUT = 64
) (
    input logic            clk,
    input logic            rst,
    kd_tree_ctrl_if.master bus
);
    localparam int            SW         = $clog2(SORT_TIMEOUT + 1);
    localparam int            PW         = $clog2(PROP_TIMEOUT + 1);
    localparam logic [SW-1:0] SORT_LIMIT = SW'(SORT_TIMEOUT);
    localparam logic [PW-1:0] PROP_LIMIT = PW'(PROP_TIMEOUT);

    kd_state_e             state_q, state_d;
    logic [15:0]           num_q, num_d;
    logic [15:0]           point_cnt_q, point_cnt_d;
    logic [SW-1:0]         sort_cnt_q, sort_cnt_d;
    logic [PW-1:0]         prop_cnt_q, prop_cnt_d;
    logic [CENTER_SIZE-1:0] root_point_q, root_point_d;
    logic [CENTER_SIZE-1:0] res_point_q, res_point_d;
    logic [CENTER_SIZE-1:0] res_center_q, res_center_d;
    logic                  err_q, err_d;
    logic                  en_q, en_d;
    logic                  sorting_q, sorting_d;
    logic                  point_prop_q, point_prop_d;
    logic                  pt_ready_q, pt_ready_d;
    logic                  res_valid_q, res_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  start_acc_s;
    logic                  run_done_s;

    assign start_acc_s = (state_q == ST_IDLE) && bus.start;

    kd_stable_detect #(
        .NUM_CE     (NUM_CE),
        .STABLE_RUN (STABLE_RUN)
    ) u_stable (
        .clk         (clk),
        .rst         (rst),
        .clr         (start_acc_s),
        .en          (state_q == ST_SORT),
        .sort_stable (bus.sort_stable),
        .run_done    (run_done_s)
    );

    // Next-state, datapath and counter updates.
    always_comb begin
        state_d      = state_q;
        num_d        = num_q;
        point_cnt_d  = point_cnt_q;
        sort_cnt_d   = sort_cnt_q;
        prop_cnt_d   = prop_cnt_q;
        root_point_d = root_point_q;
        res_point_d  = res_point_q;
        res_center_d = res_center_q;
        err_d        = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    num_d       = bus.num_points;
                    err_d       = 1'b0;
                    point_cnt_d = 16'd0;
                    sort_cnt_d  = '0;
                    state_d     = ST_SORT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SORT: begin
                sort_cnt_d = sort_cnt_q + SW'(1'b1);
                // Stability takes priority over a coincident timeout.
                if (run_done_s) begin
                    state_d = (num_q == 16'd0) ? ST_DONE : ST_FETCH;
                end else if (sort_cnt_d == SORT_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SORT;
                end
            end
            ST_FETCH: begin
                if (bus.pt_valid && pt_ready_q) begin
                    root_point_d = bus.pt_data;
                    prop_cnt_d   = '0;
                    state_d      = ST_PROP;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_PROP: begin
                prop_cnt_d = prop_cnt_q + PW'(1'b1);
                // prop_cnt_q == 0 marks the entry cycle, where best_valid is stale.
                if ((prop_cnt_q != '0) && bus.best_valid) begin
                    res_center_d = bus.best_center;
                    res_point_d  = root_point_q;
                    state_d      = ST_EMIT;
                end else if (prop_cnt_d == PROP_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PROP;
                end
            end
            ST_EMIT: begin
                if (res_valid_q && bus.res_ready) begin
                    point_cnt_d = point_cnt_q + 16'd1;
                    state_d     = is_last_point(point_cnt_q, num_q) ? ST_DONE : ST_FETCH;
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the next state so they register alongside it.
    always_comb begin
        en_d         = (state_d == ST_SORT) || (state_d == ST_PROP);
        sorting_d    = (state_d == ST_SORT);
        point_prop_d = (state_d == ST_PROP);
        pt_ready_d   = (state_d == ST_FETCH);
        res_valid_d  = (state_d == ST_EMIT);
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);
    end

    // State, counters, datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            num_q        <= 16'd0;
            point_cnt_q  <= 16'd0;
            sort_cnt_q   <= '0;
            prop_cnt_q   <= '0;
            root_point_q <= '0;
            res_point_q  <= '0;
            res_center_q <= '0;
            err_q        <= 1'b0;
            en_q         <= 1'b0;
            sorting_q    <= 1'b0;
            point_prop_q <= 1'b0;
            pt_ready_q   <= 1'b0;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            point_cnt_q  <= point_cnt_d;
            sort_cnt_q   <= sort_cnt_d;
            prop_cnt_q   <= prop_cnt_d;
            root_point_q <= root_point_d;
            res_point_q  <= res_point_d;
            res_center_q <= res_center_d;
            err_q        <= err_d;
            en_q         <= en_d;
            sorting_q    <= sorting_d;
            point_prop_q <= point_prop_d;
            pt_ready_q   <= pt_ready_d;
            res_valid_q  <= res_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.en          = en_q;
    assign bus.sorting     = sorting_q;
    assign bus.point_prop  = point_prop_q;
    assign bus.pt_ready    = pt_ready_q;
    assign bus.root_point  = root_point_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_point   = res_point_q;
    assign bus.res_center  = res_center_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err_timeout = err_q;
endmodule
